// File: rtl/ioctl_streamer.sv
// ioctl_streamer: drains a valid/ready byte source into an ioctl download port.
// Setup and hold windows bracket the transfer; each write is followed by WR_GAP idle cycles.
module ioctl_streamer #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned WR_GAP    = 3
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  index,
  input  logic [24:0] length,
  input  logic        src_valid,
  input  logic [7:0]  src_data,
  output logic        src_ready,
  output logic        ioctl_download,
  output logic [7:0]  ioctl_index,
  output logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_dout,
  output logic        ioctl_wr,
  output logic        busy,
  output logic        done
);

  localparam int unsigned TMAX = (SETUP_CYC > WR_GAP) ? SETUP_CYC : WR_GAP;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  // SETUP_CYC is expected to be at least 1; WR_GAP may be 0.
  localparam logic [TW-1:0] SETUP_LAST = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'((WR_GAP > 0) ? (WR_GAP - 1) : 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    FETCH = 3'd2,
    WRITE = 3'd3,
    GAP   = 3'd4,
    HOLD  = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [24:0]   cnt, cnt_n;
  logic [24:0]   len, len_n;
  logic [24:0]   cnt_inc;
  logic [7:0]    index_n;
  logic [24:0]   addr_n;
  logic [7:0]    dout_n;
  logic          done_n;

  assign cnt_inc = cnt + 25'd1;

  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    cnt_n   = cnt;
    len_n   = len;
    index_n = ioctl_index;
    addr_n  = ioctl_addr;
    dout_n  = ioctl_dout;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          len_n   = length;
          index_n = index;
          cnt_n   = '0;
          tmr_n   = '0;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (tmr == SETUP_LAST) begin
          tmr_n   = '0;
          state_n = (len != '0) ? FETCH : HOLD;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      FETCH: begin
        if (src_valid) begin
          dout_n  = src_data;
          addr_n  = cnt;
          state_n = WRITE;
        end
      end
      WRITE: begin
        cnt_n = cnt_inc;
        tmr_n = '0;
        // With no gap the continue/finish decision is made here on the incremented count.
        if (WR_GAP == 0) state_n = (cnt_inc < len) ? FETCH : HOLD;
        else             state_n = GAP;
      end
      GAP: begin
        if (tmr == GAP_LAST) begin
          tmr_n   = '0;
          state_n = (cnt < len) ? FETCH : HOLD;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      HOLD: begin
        if (tmr == SETUP_LAST) begin
          tmr_n   = '0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      tmr            <= '0;
      cnt            <= '0;
      len            <= '0;
      ioctl_index    <= '0;
      ioctl_addr     <= '0;
      ioctl_dout     <= '0;
      ioctl_wr       <= 1'b0;
      ioctl_download <= 1'b0;
      src_ready      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_n;
      tmr            <= tmr_n;
      cnt            <= cnt_n;
      len            <= len_n;
      ioctl_index    <= index_n;
      ioctl_addr     <= addr_n;
      ioctl_dout     <= dout_n;
      ioctl_wr       <= (state_n == WRITE);
      ioctl_download <= (state_n != IDLE);
      src_ready      <= (state_n == FETCH);
      busy           <= (state_n != IDLE);
      done           <= done_n;
    end
  end

endmodule

// File: tb/tb_ioctl_streamer.sv
// Scoreboard bench for ioctl_streamer: default instance with random traffic, plus a WR_GAP=0 instance.
module tb_ioctl_streamer;
  localparam int unsigned SC = 2;
  localparam int unsigned WG = 3;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } beat_t;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  index = '0;
  logic [24:0] length = '0;
  logic        src_valid = 1'b0;
  logic [7:0]  src_data = '0;
  logic        src_ready, ioctl_download, ioctl_wr, busy, done;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;

  logic        start1 = 1'b0;
  logic [7:0]  index1 = '0;
  logic [24:0] length1 = '0;
  logic [7:0]  src_data1 = '0;
  logic        src_ready1, ioctl_download1, ioctl_wr1, busy1, done1;
  logic [7:0]  ioctl_index1, ioctl_dout1;
  logic [24:0] ioctl_addr1;

  ioctl_streamer #(.SETUP_CYC(SC), .WR_GAP(WG)) u_dut (
    .clk_sys(clk_sys), .reset(reset), .start(start), .index(index), .length(length),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .busy(busy), .done(done)
  );

  ioctl_streamer #(.SETUP_CYC(SC), .WR_GAP(0)) u_dut_g0 (
    .clk_sys(clk_sys), .reset(reset), .start(start1), .index(index1), .length(length1),
    .src_valid(1'b1), .src_data(src_data1), .src_ready(src_ready1),
    .ioctl_download(ioctl_download1), .ioctl_index(ioctl_index1), .ioctl_addr(ioctl_addr1),
    .ioctl_dout(ioctl_dout1), .ioctl_wr(ioctl_wr1), .busy(busy1), .done(done1)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: one transfer in flight, bytes numbered in handshake order.
  beat_t       exp_q[$];
  bit          active = 0;
  bit          hold_valid = 0;
  int unsigned m_len = 0;
  logic [7:0]  m_index = '0;
  int unsigned m_start_cyc = 0;
  logic [24:0] hs_idx = '0;

  beat_t       exp1_q[$];
  bit          active1 = 0;
  logic [24:0] hs1 = '0;

  always @(negedge clk_sys) begin
    if (reset) begin
      src_valid = 1'b0;
    end else begin
      src_valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
      src_data  = 8'($urandom);
      if (src_valid && src_ready) begin
        exp_q.push_back({hs_idx, src_data});
        hs_idx++;
      end
    end
  end

  always @(negedge clk_sys) begin
    if (!reset && src_ready1) begin
      src_data1 = 8'($urandom);
      exp1_q.push_back({hs1, src_data1});
      hs1++;
    end
  end

  bit          prev_dl = 0;
  int unsigned wr_n = 0, dl_cycles = 0, rdy_n = 0, last_wr = 0;

  always @(negedge clk_sys) begin
    beat_t b;
    if (reset) begin
      prev_dl = 0; wr_n = 0; dl_cycles = 0; rdy_n = 0; last_wr = 0;
    end else begin
      if (ioctl_download && !prev_dl) check("dl_rise", cyc, m_start_cyc + 1);
      if (ioctl_download) dl_cycles++;
      if (src_ready) rdy_n++;
      if (ioctl_wr) begin
        check("wr_has_handshake", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          check("wr_addr", ioctl_addr, b.addr);
          check("wr_dout", ioctl_dout, b.data);
        end
        check("wr_index", ioctl_index, m_index);
        check("wr_busy", busy, 1);
        if (wr_n > 0) begin
          if (hold_valid) check("wr_spacing", cyc - last_wr, WG + 2);
          else            check("wr_spacing_min", (cyc - last_wr) >= WG + 2, 1);
        end else if (hold_valid) begin
          check("first_wr", cyc, m_start_cyc + SC + 2);
        end
        last_wr = cyc;
        wr_n++;
      end
      if (done) begin
        check("done_expected", active, 1);
        check("done_dl_fall", {prev_dl, ioctl_download}, 2'b10);
        check("done_busy", busy, 0);
        check("done_writes", wr_n, m_len);
        check("done_pending", exp_q.size(), 0);
        if (m_len == 0) begin
          check("len0_dl_cycles", dl_cycles, 2 * SC);
          check("len0_ready", rdy_n, 0);
        end else begin
          check("done_after_wr", cyc - last_wr, WG + 1 + SC);
        end
        active = 0; wr_n = 0; dl_cycles = 0; rdy_n = 0;
      end
      prev_dl = ioctl_download;
    end
  end

  int unsigned wr1_n = 0, last_wr1 = 0;
  always @(negedge clk_sys) begin
    beat_t b;
    if (reset) begin
      wr1_n = 0;
    end else begin
      if (ioctl_wr1) begin
        check("g0_has_handshake", exp1_q.size() != 0, 1);
        if (exp1_q.size() != 0) begin
          b = exp1_q.pop_front();
          check("g0_addr", ioctl_addr1, b.addr);
          check("g0_dout", ioctl_dout1, b.data);
        end
        check("g0_index", ioctl_index1, 254);
        if (wr1_n > 0) check("g0_spacing", cyc - last_wr1, 2);
        last_wr1 = cyc;
        wr1_n++;
      end
      if (done1) begin
        check("g0_writes", wr1_n, 8);
        check("g0_pending", exp1_q.size(), 0);
        active1 = 0; wr1_n = 0;
      end
    end
  end

  task automatic do_start(input logic [7:0] idx, input logic [24:0] len);
    @(negedge clk_sys);
    start = 1'b1; index = idx; length = len;
    if (!active) begin
      active = 1; m_len = len; m_index = idx; m_start_cyc = cyc; hs_idx = '0;
    end
    @(negedge clk_sys);
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned n = 0;
    while (active && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    check("done_in_budget", active, 0);
    active = 0;
    exp_q.delete();
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {ioctl_download, ioctl_wr, busy, done, src_ready}, 0);
    check({tag, "_addr"}, ioctl_addr, 0);
    check({tag, "_dout"}, ioctl_dout, 0);
    check({tag, "_index"}, ioctl_index, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    #1 reset = 1'b1;
    #3;
    check_all_zero("reset0");
    check("reset0_g0", {ioctl_download1, ioctl_wr1, busy1, done1, src_ready1}, 0);
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);

    hold_valid = 1;
    do_start(8'h00, 25'd4);
    wait_done(200);

    do_start(8'h10, 25'd0);
    wait_done(100);

    hold_valid = 0;
    do_start(8'h03, 25'd3);
    wait_done(300);

    do_start(8'h5A, 25'd6);
    repeat (10) @(negedge clk_sys);
    do_start(8'd254, 25'd3);
    check("busy_start_index", ioctl_index, 8'h5A);
    wait_done(400);

    for (int t = 0; t < 8; t++) begin
      hold_valid = 1'($urandom_range(0, 1));
      do_start(8'($urandom), 25'($urandom_range(1, 10)));
      wait_done(600);
    end

    hold_valid = 1;
    do_start(8'h11, 25'd8);
    n = 0;
    while (wr_n < 2 && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    check("second_wr_seen", wr_n, 2);
    @(posedge clk_sys);
    #2 reset = 1'b1;
    #1;
    check_all_zero("reset_mid");
    active = 0;
    exp_q.delete();
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    do_start(8'h22, 25'd2);
    wait_done(200);

    @(negedge clk_sys);
    start1 = 1'b1; index1 = 8'd254; length1 = 25'd8;
    active1 = 1; hs1 = '0;
    @(negedge clk_sys);
    start1 = 1'b0;
    n = 0;
    while (active1 && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    check("g0_done_in_budget", active1, 0);
    repeat (3) @(negedge clk_sys);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
